// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if
// Byte-stream bundle between the UART and the command sequencer.
//   rx_data/rx_valid : received byte and its one-cycle strobe (UART -> sequencer)
//   tx_data/tx_valid : status byte and its pending flag      (sequencer -> UART)
//   tx_ready         : UART TX can take a byte               (UART -> sequencer)
// The master modport is the UART side, and the slave modport is the sequencer side.
interface uart_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
// Routes the UART RX byte stream. In IDLE, bytes go to the 7-seg display register.
// After an 'M', framed commands set the LED rate, PWM duty and LED pattern, and each
// result is answered on UART TX with 'K' (ok) or 'E' (error).
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   bus (slave)   : rx_data/rx_valid in, tx_data/tx_valid out, tx_ready in
//   seg_data/stb  : display byte and a one-cycle update pulse
//   rate_control  : LED blink rate select (11 = default)
//   pwm_duty      : PWM duty byte
//   led_pattern   : LED pattern byte
//   cmd_mode      : high whenever the FSM is not in IDLE
//   drop_cnt      : saturating count of rx bytes that arrived while a status byte was pending
module uart_cmd_sequencer #(
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int ACK_EN      = 1,
    parameter int DROP_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    uart_cmd_sequencer_if.slave bus,
    output logic [7:0]        seg_data,
    output logic              seg_stb,
    output logic [1:0]        rate_control,
    output logic [7:0]        pwm_duty,
    output logic [7:0]        led_pattern,
    output logic              cmd_mode,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ARG_RATE, S_ARG_HI, S_ARG_LO, S_ACK
    } state_t;

    state_t            state_q, state_n;
    state_t            ret_q, ret_n;        // where ACK goes once the status byte is taken
    state_t            ack_ret;
    logic [3:0]        hi_q, hi_n;          // high nibble of a pending argument
    logic              tgt_led_q, tgt_led_n; // 1: argument targets led_pattern, 0: pwm_duty
    logic [TO_W-1:0]   to_q, to_n;
    logic [7:0]        tx_data_q, tx_data_n;
    logic              tx_valid_q, tx_valid_n;
    logic [7:0]        seg_data_n;
    logic              seg_stb_n;
    logic [1:0]        rate_n;
    logic [7:0]        pwm_n, led_n;
    logic [DROP_W-1:0] drop_n;
    logic              ack_go;
    logic [7:0]        ack_byte;

    logic [7:0] rx_up;
    logic       rx_hex;
    logic [3:0] rx_nib;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    // Letters are matched case-insensitively by folding to upper case first.
    assign rx_up  = to_upper(bus.rx_data);
    assign rx_hex = (rx_up >= 8'h30 && rx_up <= 8'h39) || (rx_up >= 8'h41 && rx_up <= 8'h46);
    // '0'-'9' map straight from the low nibble; 'A'-'F' (0x41..) need +9 to reach 10..15.
    assign rx_nib = (rx_up <= 8'h39) ? rx_up[3:0] : rx_up[3:0] + 4'd9;

    always_comb begin
        state_n    = state_q;
        ret_n      = ret_q;
        hi_n       = hi_q;
        tgt_led_n  = tgt_led_q;
        to_n       = to_q;
        tx_data_n  = tx_data_q;
        seg_data_n = seg_data;
        seg_stb_n  = 1'b0;
        rate_n     = rate_control;
        pwm_n      = pwm_duty;
        led_n      = led_pattern;
        drop_n     = drop_cnt;
        ack_go     = 1'b0;
        ack_byte   = CH_K;
        ack_ret    = S_CMD;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (rx_up == 8'h4D) begin
                        state_n = S_CMD;
                    end else if (bus.rx_data != 8'h00 && rx_up != 8'h46) begin
                        seg_data_n = bus.rx_data;
                        seg_stb_n  = 1'b1;
                    end
                end
            end
            S_CMD: begin
                if (bus.rx_valid) begin
                    case (rx_up)
                        8'h52: state_n = S_ARG_RATE;
                        8'h44: begin state_n = S_ARG_HI; tgt_led_n = 1'b0; end
                        8'h4C: begin state_n = S_ARG_HI; tgt_led_n = 1'b1; end
                        8'h4D: ;
                        8'h46: begin ack_go = 1'b1; ack_byte = CH_K; ack_ret = S_IDLE; end
                        default: begin ack_go = 1'b1; ack_byte = CH_E; end
                    endcase
                end
            end
            S_ARG_RATE: begin
                if (bus.rx_valid) begin
                    ack_go = 1'b1;
                    case (rx_up)
                        8'h31: rate_n = 2'b00;
                        8'h35: rate_n = 2'b01;
                        8'h41: rate_n = 2'b10;
                        default: ack_byte = CH_E;
                    endcase
                end
            end
            S_ARG_HI: begin
                if (bus.rx_valid) begin
                    if (rx_hex) begin
                        hi_n    = rx_nib;
                        state_n = S_ARG_LO;
                    end else begin
                        ack_go   = 1'b1;
                        ack_byte = CH_E;
                    end
                end
            end
            S_ARG_LO: begin
                if (bus.rx_valid) begin
                    ack_go = 1'b1;
                    if (rx_hex) begin
                        if (tgt_led_q) led_n = {hi_q, rx_nib};
                        else           pwm_n = {hi_q, rx_nib};
                    end else begin
                        ack_byte = CH_E;
                    end
                end
            end
            S_ACK: begin
                // The UART is still busy with our status byte, so any byte arriving now is lost.
                if (bus.rx_valid && drop_cnt != '1) drop_n = drop_cnt + DROP_W'(1);
                if (bus.tx_ready) state_n = ret_q;
            end
            default: state_n = S_IDLE;
        endcase

        if (ack_go) begin
            if (ACK_EN != 0) begin
                state_n   = S_ACK;
                ret_n     = ack_ret;
                tx_data_n = ack_byte;
            end else begin
                state_n = ack_ret;
            end
        end

        // The inactivity watchdog runs only while a command is being framed.
        // Expiry abandons the command silently, and nothing has been committed yet.
        if (state_q == S_IDLE || state_q == S_ACK || bus.rx_valid) begin
            to_n = '0;
        end else if (to_q == TO_LAST) begin
            to_n    = '0;
            state_n = S_IDLE;
        end else begin
            to_n = to_q + TO_W'(1);
        end

        tx_valid_n = (ACK_EN != 0) && (state_n == S_ACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ret_q        <= S_CMD;
            hi_q         <= '0;
            tgt_led_q    <= 1'b0;
            to_q         <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            seg_data     <= '0;
            seg_stb      <= 1'b0;
            rate_control <= 2'b11;
            pwm_duty     <= '0;
            led_pattern  <= '0;
            drop_cnt     <= '0;
        end else begin
            state_q      <= state_n;
            ret_q        <= ret_n;
            hi_q         <= hi_n;
            tgt_led_q    <= tgt_led_n;
            to_q         <= to_n;
            tx_data_q    <= tx_data_n;
            tx_valid_q   <= tx_valid_n;
            seg_data     <= seg_data_n;
            seg_stb      <= seg_stb_n;
            rate_control <= rate_n;
            pwm_duty     <= pwm_n;
            led_pattern  <= led_n;
            drop_cnt     <= drop_n;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign cmd_mode     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
module tb_uart_cmd_sequencer;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_data;
    logic       seg_stb;
    logic [1:0] rate_control;
    logic [7:0] pwm_duty;
    logic [7:0] led_pattern;
    logic       cmd_mode;
    logic [3:0] drop_cnt;

    uart_cmd_sequencer_if bus();

    uart_cmd_sequencer #(.TIMEOUT_CYC(TO), .ACK_EN(1), .DROP_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .seg_data(seg_data), .seg_stb(seg_stb), .rate_control(rate_control),
        .pwm_duty(pwm_duty), .led_pattern(led_pattern), .cmd_mode(cmd_mode),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] rx;
        logic       ack;
        logic [7:0] ack_b;
        logic       cmd;
        logic [1:0] rate;
        logic [7:0] pwm;
        logic [7:0] led;
        logic [7:0] seg;
    } vec_t;

    vec_t vt[27];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One-cycle rx strobe, and the byte is accepted on the next edge.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard side: pop on each transfer, check hold while stalled, and watch seg_stb.
    logic       prev_v = 1'b0;
    logic       prev_x = 1'b0;
    logic [7:0] prev_d = 8'h00;
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tx actual=%0h expected=none", bus.tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.tx_data !== e) begin
                    bad++;
                    $display("FAIL tx_byte actual=%0h expected=%0h", bus.tx_data, e);
                end
            end
        end
        if (bus.tx_valid && prev_v && !prev_x) begin
            total++;
            if (bus.tx_data !== prev_d) begin
                bad++;
                $display("FAIL tx_hold actual=%0h expected=%0h", bus.tx_data, prev_d);
            end
        end
        if (seg_stb) begin
            total++;
            if (cmd_mode !== 1'b0) begin
                bad++;
                $display("FAIL seg_stb_in_cmd actual=%0b expected=0", cmd_mode);
            end
        end
        prev_v = bus.tx_valid;
        prev_d = bus.tx_data;
        prev_x = bus.tx_valid && bus.tx_ready;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rx     ack ack_b  cmd rate   pwm    led    seg
        vt[0]  = '{8'h6D, 0, 8'h00, 1, 2'b11, 8'h00, 8'h00, 8'h48}; // m
        vt[1]  = '{8'h52, 0, 8'h00, 1, 2'b11, 8'h00, 8'h00, 8'h48}; // R
        vt[2]  = '{8'h35, 1, 8'h4B, 1, 2'b01, 8'h00, 8'h00, 8'h48}; // 5
        vt[3]  = '{8'h4D, 0, 8'h00, 1, 2'b01, 8'h00, 8'h00, 8'h48}; // M ignored
        vt[4]  = '{8'h44, 0, 8'h00, 1, 2'b01, 8'h00, 8'h00, 8'h48}; // D
        vt[5]  = '{8'h38, 0, 8'h00, 1, 2'b01, 8'h00, 8'h00, 8'h48}; // 8
        vt[6]  = '{8'h63, 1, 8'h4B, 1, 2'b01, 8'h8C, 8'h00, 8'h48}; // c
        vt[7]  = '{8'h46, 1, 8'h4B, 0, 2'b01, 8'h8C, 8'h00, 8'h48}; // F
        vt[8]  = '{8'h4D, 0, 8'h00, 1, 2'b01, 8'h8C, 8'h00, 8'h48}; // M
        vt[9]  = '{8'h4C, 0, 8'h00, 1, 2'b01, 8'h8C, 8'h00, 8'h48}; // L
        vt[10] = '{8'h47, 1, 8'h45, 1, 2'b01, 8'h8C, 8'h00, 8'h48}; // G bad hex
        vt[11] = '{8'h4C, 0, 8'h00, 1, 2'b01, 8'h8C, 8'h00, 8'h48}; // L
        vt[12] = '{8'h61, 0, 8'h00, 1, 2'b01, 8'h8C, 8'h00, 8'h48}; // a
        vt[13] = '{8'h35, 1, 8'h4B, 1, 2'b01, 8'h8C, 8'hA5, 8'h48}; // 5
        vt[14] = '{8'h52, 0, 8'h00, 1, 2'b01, 8'h8C, 8'hA5, 8'h48}; // R
        vt[15] = '{8'h78, 1, 8'h45, 1, 2'b01, 8'h8C, 8'hA5, 8'h48}; // x bad rate
        vt[16] = '{8'h71, 1, 8'h45, 1, 2'b01, 8'h8C, 8'hA5, 8'h48}; // q bad cmd
        vt[17] = '{8'h72, 0, 8'h00, 1, 2'b01, 8'h8C, 8'hA5, 8'h48}; // r
        vt[18] = '{8'h61, 1, 8'h4B, 1, 2'b10, 8'h8C, 8'hA5, 8'h48}; // a
        vt[19] = '{8'h44, 0, 8'h00, 1, 2'b10, 8'h8C, 8'hA5, 8'h48}; // D
        vt[20] = '{8'h31, 0, 8'h00, 1, 2'b10, 8'h8C, 8'hA5, 8'h48}; // 1
        vt[21] = '{8'h7A, 1, 8'h45, 1, 2'b10, 8'h8C, 8'hA5, 8'h48}; // z bad lo
        vt[22] = '{8'h66, 1, 8'h4B, 0, 2'b10, 8'h8C, 8'hA5, 8'h48}; // f
        vt[23] = '{8'h00, 0, 8'h00, 0, 2'b10, 8'h8C, 8'hA5, 8'h48}; // NUL ignored
        vt[24] = '{8'h46, 0, 8'h00, 0, 2'b10, 8'h8C, 8'hA5, 8'h48}; // F ignored in IDLE
        vt[25] = '{8'h5A, 0, 8'h00, 0, 2'b10, 8'h8C, 8'hA5, 8'h5A}; // Z to display
        vt[26] = '{8'h42, 0, 8'h00, 0, 2'b10, 8'h8C, 8'hA5, 8'h42}; // B to display

        reset = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        cycles(3);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_seg", {seg_stb, seg_data}, 9'h000);
        chk("rst_cfg", {rate_control, pwm_duty, led_pattern}, {2'b11, 8'h00, 8'h00});
        chk("rst_drop_cmd", {drop_cnt, cmd_mode}, 5'h00);
        reset = 1'b0;
        cycles(1);

        send(8'h48);
        chk("H_seg", {seg_stb, seg_data, cmd_mode}, {1'b1, 8'h48, 1'b0});
        cycles(1);
        chk("H_stb_pulse", seg_stb, 1'b0);

        for (int i = 0; i < 27; i++) begin
            if (vt[i].ack) exp_q.push_back(vt[i].ack_b);
            send(vt[i].rx);
            cycles(2);
            chk($sformatf("vec%0d", i),
                {cmd_mode, rate_control, pwm_duty, led_pattern, seg_data},
                {vt[i].cmd, vt[i].rate, vt[i].pwm, vt[i].led, vt[i].seg});
        end
        chk("vec_q_empty", exp_q.size(), 0);

        // Stalled ACK: bytes are dropped, including the handshake cycle.
        bus.tx_ready = 1'b0;
        send(8'h4D);
        exp_q.push_back(8'h45);
        send(8'h51);
        send(8'h78); send(8'h79); send(8'h7A);
        cycles(3);
        chk("stall_drop3", drop_cnt, 4'd3);
        chk("stall_valid", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h45});
        bus.tx_ready = 1'b1;
        send(8'h77);
        chk("hs_exit", {bus.tx_valid, cmd_mode}, 2'b01);
        chk("hs_drop4", drop_cnt, 4'd4);
        cycles(2);
        chk("stall_q_empty", exp_q.size(), 0);

        // Drop counter saturation.
        bus.tx_ready = 1'b0;
        exp_q.push_back(8'h45);
        send(8'h5A);
        for (int i = 0; i < 11; i++) send(8'h30);
        chk("drop_15", drop_cnt, 4'hF);
        for (int i = 0; i < 3; i++) send(8'h30);
        chk("drop_sat", drop_cnt, 4'hF);
        bus.tx_ready = 1'b1;
        cycles(3);
        chk("sat_q_empty", exp_q.size(), 0);
        chk("sat_in_cmd", cmd_mode, 1'b1);

        // Inactivity abort mid-argument.
        send(8'h4D); send(8'h44); send(8'h33);
        cycles(TO - 1);
        chk("to_before", cmd_mode, 1'b1);
        cycles(1);
        chk("to_after", cmd_mode, 1'b0);
        chk("to_pwm", pwm_duty, 8'h8C);
        cycles(2);
        chk("to_no_tx", exp_q.size(), 0);

        // Reset while a status byte is pending.
        bus.tx_ready = 1'b0;
        send(8'h4D);
        send(8'h51);
        chk("pre_rst_valid", bus.tx_valid, 1'b1);
        reset = 1'b1;
        cycles(1);
        exp_q.delete();
        chk("mid_rst_tx", {bus.tx_valid, bus.tx_data}, 9'h000);
        chk("mid_rst_seg", {seg_stb, seg_data}, 9'h000);
        chk("mid_rst_cfg", {rate_control, pwm_duty, led_pattern}, {2'b11, 8'h00, 8'h00});
        chk("mid_rst_misc", {drop_cnt, cmd_mode}, 5'h00);
        reset = 1'b0;
        bus.tx_ready = 1'b1;
        cycles(4);
        chk("post_rst_idle", {bus.tx_valid, cmd_mode}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
